hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline control block that produces the load enables and bubble/flush controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers.
- It watches the instruction held in the ID/EX register, the instruction in IF/ID, the branch resolution and the data-memory busy flag.
- It decides per cycle whether each pipeline register advances, holds, or receives a bubble.
- It includes a multi-cycle load-use stall FSM and a saturating stall-cycle counter for performance debug.

Parameters:
LOAD_STALL, 1, bubble cycles inserted per load-use hazard (legal 1..15)
CNT_W, 16, width of stall statistics counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
idex_memread  in  1  memread held in ID/EX register
idex_rt  in  5  rt (load destination) held in ID/EX register
ifid_rs  in  5  rs field of instruction in IF/ID
ifid_rt  in  5  rt field of instruction in IF/ID
ifid_uses_rt  in  1  instruction in IF/ID reads rt as a source
branch_taken  in  1  branch/jump resolved taken this cycle
dmem_busy  in  1  data memory not ready; whole pipe must freeze
pc_ld  out  1  PC write enable
ifid_ld  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID synchronous clear
idex_ld  out  1  ID/EX load enable
idex_bubble  out  1  force all ID/EX control inputs (aluop, alusrc, regdst, memwrite, memread, memtoreg, regwrite) to 0
exmem_ld  out  1  EX/MEM load enable
stall_cnt  out  CNT_W  saturating count of cycles with pc_ld=0

Behaviour:
- Reset (rst=0, async):
  - state=RUN, remaining=0, stall_cnt=0.
  - Outputs are forced to pc_ld=0, ifid_ld=0, idex_ld=0, exmem_ld=0, ifid_flush=0, idex_bubble=0 regardless of inputs.
  - The first rising edge after deassertion behaves as RUN.
- hazard (combinational):
  - hazard = idex_memread & (idex_rt!=0) & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)).
  - Register 0 never causes a hazard.
- States:
  - RUN: normal operation.
  - LSTALL: extra load-use stall cycles; remaining (4 bits) counts them down.
- Output priority per cycle, highest first:
  1. dmem_busy=1: pc_ld=ifid_ld=idex_ld=exmem_ld=0, flush=0, bubble=0. State and remaining hold. Freeze overrides everything, including a pending branch_taken, which must be re-presented by its source.
  2. branch_taken=1: pc_ld=1, ifid_ld=1, ifid_flush=1, idex_ld=1, idex_bubble=1, exmem_ld=1. Next state=RUN, remaining=0. This aborts any LSTALL.
  3. RUN & hazard: pc_ld=0, ifid_ld=0, idex_ld=1, idex_bubble=1, exmem_ld=1, flush=0.
     - LOAD_STALL=1: stay RUN.
     - LOAD_STALL>1: next state=LSTALL, remaining=LOAD_STALL-1.
  4. LSTALL: same outputs as item 3, independent of hazard.
     - At the edge: remaining decrements.
     - When remaining==1 at the edge, next state=RUN.
  5. Otherwise: all ld=1, flush=0, bubble=0.
- Latency:
  - Load-use bubble count is exactly LOAD_STALL cycles from the first cycle hazard is seen.
  - Hazard detection is combinational; no added latency.
- stall_cnt:
  - Increments by 1 on each rising edge where pc_ld=0, including dmem_busy freezes.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- Hazard reappearing in RUN after an LSTALL completes starts a new stall. This is legal when a new load sits in ID/EX.
- Reset mid-LSTALL returns immediately to RUN with remaining=0.

Test Plan:
- Reset: rst=0 with branch_taken=1, hazard inputs active -> all outputs 0, stall_cnt=0. Release rst, no hazard -> pc_ld=ifid_ld=idex_ld=exmem_ld=1 on the next cycle.
- Load-use, LOAD_STALL=1: idex_memread=1, idex_rt=8, ifid_rs=8 for one cycle -> that cycle pc_ld=0, ifid_ld=0, idex_bubble=1, idex_ld=1. Next cycle (idex_memread=0) -> normal; stall_cnt=1. Repeat with idex_rt=0 -> no stall.
- rt dependency: idex_rt=5, ifid_rt=5, ifid_rs=3.
  - ifid_uses_rt=0 -> no stall.
  - ifid_uses_rt=1 -> stall.
- LOAD_STALL=3: hazard for 1 cycle then idex_memread=0 -> exactly 3 consecutive cycles of pc_ld=0/idex_bubble=1, then RUN; stall_cnt=3.
- LOAD_STALL=3 interrupted: hazard, then dmem_busy=1 for 2 cycles in LSTALL -> all ld=0 during busy, remaining held; 2 more bubble cycles after busy; stall_cnt=5. Second run: branch_taken=1 in 2nd LSTALL cycle -> ifid_flush=1, pc_ld=1, then RUN.
- Saturation, CNT_W=4: hold dmem_busy=1 for 20 cycles -> stall_cnt reaches 15 and stays 15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard status in, pipeline register controls out
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             idex_memread;
   logic [4:0]       idex_rt;
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             ifid_uses_rt;
   logic             branch_taken;
   logic             dmem_busy;
   logic             pc_ld;
   logic             ifid_ld;
   logic             ifid_flush;
   logic             idex_ld;
   logic             idex_bubble;
   logic             exmem_ld;
   logic [CNT_W-1:0] stall_cnt;

   // pipeline side: reports status, consumes controls
   modport master (
      output idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, branch_taken, dmem_busy,
      input  pc_ld, ifid_ld, ifid_flush, idex_ld, idex_bubble, exmem_ld, stall_cnt
   );

   // hazard controller side
   modport slave (
      input  idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, branch_taken, dmem_busy,
      output pc_ld, ifid_ld, ifid_flush, idex_ld, idex_bubble, exmem_ld, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush and memory freeze control
module hazard_ctrl #(
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave hif
);

   typedef enum logic {
      S_RUN,
      S_LSTALL
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       remaining_q, remaining_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic hazard;
   logic pc_ld, ifid_ld, ifid_flush, idex_ld, idex_bubble, exmem_ld;

   // load in ID/EX whose destination is a source of the IF/ID instruction; r0 is never a hazard
   always_comb begin
      hazard = hif.idex_memread && (hif.idex_rt != 5'd0) &&
               ((hif.idex_rt == hif.ifid_rs) ||
                (hif.ifid_uses_rt && (hif.idex_rt == hif.ifid_rt)));
   end

   // per-cycle control decision: freeze > branch flush > load-use bubble > run
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      pc_ld       = 1'b0;
      ifid_ld     = 1'b0;
      ifid_flush  = 1'b0;
      idex_ld     = 1'b0;
      idex_bubble = 1'b0;
      exmem_ld    = 1'b0;
      if (!rst) begin
         state_d     = S_RUN;
         remaining_d = 4'd0;
      end else if (hif.dmem_busy) begin
         // whole pipe frozen, stall progress held
      end else if (hif.branch_taken) begin
         pc_ld       = 1'b1;
         ifid_ld     = 1'b1;
         ifid_flush  = 1'b1;
         idex_ld     = 1'b1;
         idex_bubble = 1'b1;
         exmem_ld    = 1'b1;
         state_d     = S_RUN;
         remaining_d = 4'd0;
      end else if (state_q == S_LSTALL) begin
         idex_ld     = 1'b1;
         idex_bubble = 1'b1;
         exmem_ld    = 1'b1;
         remaining_d = remaining_q - 4'd1;
         if (remaining_q == 4'd1) begin
            state_d = S_RUN;
         end
      end else if (hazard) begin
         idex_ld     = 1'b1;
         idex_bubble = 1'b1;
         exmem_ld    = 1'b1;
         if (LOAD_STALL > 1) begin
            state_d     = S_LSTALL;
            remaining_d = 4'(LOAD_STALL - 1);
         end
      end else begin
         pc_ld    = 1'b1;
         ifid_ld  = 1'b1;
         idex_ld  = 1'b1;
         exmem_ld = 1'b1;
      end
   end

   // saturating count of cycles in which the PC did not advance
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_ld && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // state, stall countdown and statistics registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_RUN;
         remaining_q <= 4'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hif.pc_ld       = pc_ld;
   assign hif.ifid_ld     = ifid_ld;
   assign hif.ifid_flush  = ifid_flush;
   assign hif.idex_ld     = idex_ld;
   assign hif.idex_bubble = idex_bubble;
   assign hif.exmem_ld    = exmem_ld;
   assign hif.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl across three configurations
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(16)) if0 ();
   hazard_ctrl_if #(.CNT_W(16)) if1 ();
   hazard_ctrl_if #(.CNT_W(4))  if2 ();

   hazard_ctrl #(.LOAD_STALL(1), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .hif(if0));
   hazard_ctrl #(.LOAD_STALL(3), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .hif(if1));
   hazard_ctrl #(.LOAD_STALL(1), .CNT_W(4))  u2 (.clk(clk), .rst(rst), .hif(if2));

   // control bit order: pc_ld, ifid_ld, ifid_flush, idex_ld, idex_bubble, exmem_ld
   logic [5:0]  g_ctl [3];
   logic [15:0] g_cnt [3];
   assign g_ctl[0] = {if0.pc_ld, if0.ifid_ld, if0.ifid_flush, if0.idex_ld, if0.idex_bubble, if0.exmem_ld};
   assign g_ctl[1] = {if1.pc_ld, if1.ifid_ld, if1.ifid_flush, if1.idex_ld, if1.idex_bubble, if1.exmem_ld};
   assign g_ctl[2] = {if2.pc_ld, if2.ifid_ld, if2.ifid_flush, if2.idex_ld, if2.idex_bubble, if2.exmem_ld};
   assign g_cnt[0] = if0.stall_cnt;
   assign g_cnt[1] = if1.stall_cnt;
   assign g_cnt[2] = {12'd0, if2.stall_cnt};

   typedef struct packed {
      logic [2:0][5:0]  ctl;
      logic [2:0][15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // reference model: bubbles still owed and stall statistics per configuration
   int ls_cfg  [3] = '{1, 3, 1};
   int max_cfg [3] = '{65535, 65535, 15};
   int owed    [3] = '{0, 0, 0};
   int cnt_m   [3] = '{0, 0, 0};

   task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s dut%0d t=%0t got=%h want=%h", name, d, $time, got, want);
      end
   endtask

   // drive one cycle of inputs and push what every configuration should show this cycle
   task automatic cyc(input bit rstn, input bit mr, input logic [4:0] rt, input logic [4:0] rs,
                      input logic [4:0] irt, input bit uses, input bit br, input bit busy);
      exp_t e;
      bit   haz;
      @(posedge clk);
      #1;
      rst = rstn;
      if0.idex_memread = mr; if1.idex_memread = mr; if2.idex_memread = mr;
      if0.idex_rt = rt;      if1.idex_rt = rt;      if2.idex_rt = rt;
      if0.ifid_rs = rs;      if1.ifid_rs = rs;      if2.ifid_rs = rs;
      if0.ifid_rt = irt;     if1.ifid_rt = irt;     if2.ifid_rt = irt;
      if0.ifid_uses_rt = uses; if1.ifid_uses_rt = uses; if2.ifid_uses_rt = uses;
      if0.branch_taken = br; if1.branch_taken = br; if2.branch_taken = br;
      if0.dmem_busy = busy;  if1.dmem_busy = busy;  if2.dmem_busy = busy;
      haz = mr && (rt != 0) && ((rt == rs) || (uses && (rt == irt)));
      for (int d = 0; d < 3; d++) begin
         if (!rstn) begin
            owed[d]  = 0;
            cnt_m[d] = 0;
            e.ctl[d] = 6'b000000;
            e.cnt[d] = 16'd0;
         end else begin
            e.cnt[d] = 16'(cnt_m[d]);
            if (busy) begin
               e.ctl[d] = 6'b000000;
            end else if (br) begin
               e.ctl[d] = 6'b111111;
               owed[d]  = 0;
            end else if (owed[d] > 0 || haz) begin
               e.ctl[d] = 6'b000111;
               owed[d]  = (owed[d] > 0) ? owed[d] - 1 : ls_cfg[d] - 1;
            end else begin
               e.ctl[d] = 6'b110101;
            end
            if (!e.ctl[d][5] && cnt_m[d] < max_cfg[d]) cnt_m[d]++;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
   endtask

   task automatic load_use8();
      cyc(1, 1, 5'd8, 5'd8, 5'd1, 0, 0, 0);
   endtask

   function automatic logic [4:0] pick_reg();
      logic [4:0] pool [4] = '{5'd0, 5'd3, 5'd5, 5'd8};
      return pool[$urandom_range(0, 3)];
   endfunction

   // monitor: every presented output cycle is checked against the oldest expectation
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         for (int d = 0; d < 3; d++) begin
            chk("ctl", d, 32'(g_ctl[d]), 32'(e.ctl[d]));
            chk("stall_cnt", d, 32'(g_cnt[d]), 32'(e.cnt[d]));
         end
      end
   end

   initial begin
      if0.idex_memread = 0; if1.idex_memread = 0; if2.idex_memread = 0;
      if0.idex_rt = 0; if1.idex_rt = 0; if2.idex_rt = 0;
      if0.ifid_rs = 0; if1.ifid_rs = 0; if2.ifid_rs = 0;
      if0.ifid_rt = 0; if1.ifid_rt = 0; if2.ifid_rt = 0;
      if0.ifid_uses_rt = 0; if1.ifid_uses_rt = 0; if2.ifid_uses_rt = 0;
      if0.branch_taken = 0; if1.branch_taken = 0; if2.branch_taken = 0;
      if0.dmem_busy = 0; if1.dmem_busy = 0; if2.dmem_busy = 0;

      // reset with branch and hazard inputs active, then release
      cyc(0, 1, 5'd8, 5'd8, 5'd8, 1, 1, 0);
      cyc(0, 1, 5'd8, 5'd8, 5'd8, 1, 1, 0);
      idle(2);

      // load-use on rs, then r0 load that must not stall
      load_use8();
      idle(4);
      cyc(1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
      idle(1);

      // rt dependency only counts when the instruction reads rt
      cyc(1, 1, 5'd5, 5'd3, 5'd5, 0, 0, 0);
      idle(1);
      cyc(1, 1, 5'd5, 5'd3, 5'd5, 1, 0, 0);
      idle(4);

      // load-use interrupted by a two-cycle memory freeze
      load_use8();
      cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
      cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
      idle(4);

      // branch taken in the second extra stall cycle
      load_use8();
      idle(1);
      cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      idle(3);

      // back-to-back loads: a new stall starts after the first completes
      load_use8();
      idle(2);
      load_use8();
      idle(4);

      // reset in the middle of a stall
      load_use8();
      cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      idle(3);

      // long freeze saturates the narrow counter
      for (int i = 0; i < 20; i++) cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
      @(negedge clk);
      #1;
      chk("sat_cnt", 2, 32'(g_cnt[2]), 32'd15);
      idle(2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 1) == 1), pick_reg(), pick_reg(),
             pick_reg(), ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 6) == 0));
      end
      idle(3);

      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
